imem_port_arbiter: RTL

//  Shares the single-port 64x32 instruction memory between the pipeline fetch stage and a

---
 rtl/imem_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port 64x32 instruction memory between the
// fetch stage and a program-load (write) port.
// Fetch has priority in S_FETCH until the loader has been starved STARVE_MAX
// times. The loader then owns the memory in S_LOAD for up to LD_BURST grants.
// Optional feature macro: IMEM_ARB_PERF_EN adds the stall_cnt and ld_cnt
// saturating performance counters.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LD_BURST   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       ld_cnt
`endif
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned BURST_W  = $clog2(LD_BURST + 1);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_LOAD  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_n;
    logic [BURST_W-1:0]  burst_cnt;
    logic [BURST_W-1:0]  burst_n;

    // Arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            burst_cnt  <= burst_n;
        end
    end

    // Grant selection and next-state; no grant is issued while reset is held
    always_comb begin
        state_n   = state;
        starve_n  = starve_cnt;
        burst_n   = burst_cnt;
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    if (ld_req && (!fetch_req || (starve_cnt == STARVE_W'(STARVE_MAX)))) begin
                        ld_gnt = 1'b1;
                    end else if (fetch_req) begin
                        fetch_gnt = 1'b1;
                    end
                    if (ld_gnt || !ld_req) begin
                        starve_n = '0;
                    end else if (fetch_gnt) begin
                        starve_n = starve_cnt + STARVE_W'(1);
                    end
                    // Starvation-forced load opens a burst; a lone load request does not
                    if (ld_gnt && fetch_req) begin
                        starve_n = '0;
                        if (LD_BURST > 1) begin
                            state_n = S_LOAD;
                            burst_n = BURST_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    starve_n = '0;
                    if (ld_req) begin
                        ld_gnt = 1'b1;
                        if ((burst_cnt + BURST_W'(1)) == BURST_W'(LD_BURST)) begin
                            state_n = S_FETCH;
                            burst_n = '0;
                        end else begin
                            burst_n = burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        fetch_gnt = fetch_req;
                        state_n   = S_FETCH;
                        burst_n   = '0;
                    end
                end
                default: begin
                    state_n = S_FETCH;
                end
            endcase
        end
    end

    // Memory-side steering: the loader's address only when it holds the grant
    assign mem_addr  = ld_gnt ? ld_addr : fetch_addr;
    assign mem_we    = ld_gnt;
    assign mem_wdata = ld_data;

    // Registered read return; data holds its last value when no fetch was granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else begin
            fetch_valid <= fetch_gnt;
            if (fetch_gnt) begin
                fetch_data <= mem_rdata;
            end
        end
    end

`ifdef IMEM_ARB_PERF_EN
    // Saturating counters of fetch stall cycles and load grant cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            ld_cnt    <= '0;
        end else begin
            if (fetch_req && !fetch_gnt && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (ld_gnt && (ld_cnt != 16'hFFFF)) begin
                ld_cnt <= ld_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
